uart_time_sender: RTL and testbench
===================================

Name: uart_time_sender

Overview:
Upstream feeder for the UART transmitter in the stopwatch/watch design. On a send request it snapshots the current time, converts it to the ASCII string "HH:MM:SS.CC\r\n", and hands the string to the transmitter one byte at a time over the start/busy/done handshake. It sits between the stopwatch/watch datapath (or the button/command logic) and the UART TX.

Parameters:
SHOW_CSEC, 1, 1 = include ".CC" (13-byte message); 0 = "HH:MM:SS\r\n" (10-byte message)
TIMEOUT, 2_000_000, clk cycles to wait for tx_done per byte before aborting

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_send  input  1  send request, sampled every cycle; one-cycle pulse expected
i_hour  input  5  hours, 0-23 (0-31 accepted)
i_min  input  6  minutes, 0-59 (0-63 accepted)
i_sec  input  6  seconds, 0-59 (0-63 accepted)
i_csec  input  7  centiseconds, 0-99 (values >99 clamped to 99)
i_tx_busy  input  1  transmitter busy
i_tx_done  input  1  transmitter one-cycle done pulse, issued after the stop bit
o_tx_start  output  1  one-cycle start pulse to the transmitter
o_tx_data  output  8  byte to transmit; held stable from start until done
o_busy  output  1  message in progress
o_done  output  1  one-cycle pulse after the last byte completes
o_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high.
- Reset values: state = IDLE; o_tx_start = 0; o_tx_data = 8'h00; o_busy = 0; o_done = 0; o_err = 0; byte index = 0; timeout counter = 0.
- States: IDLE, LOAD, SEND, WAIT.
- IDLE:
  - On i_send = 1, capture all four time inputs into snapshot registers and go to LOAD.
  - o_busy rises in the cycle after i_send.
- LOAD:
  - Register the tens/ones ASCII digits (8'h30 + digit) of each snapshot field.
  - Hold the digits for the whole message.
  - Go to SEND with index = 0.
- SEND:
  - If i_tx_busy = 0, drive o_tx_data = byte[index], pulse o_tx_start for exactly 1 cycle, clear the timeout counter, and go to WAIT.
  - If i_tx_busy = 1, stay in SEND (no pulse).
- WAIT:
  - o_tx_data is held. The transmitter samples din throughout its data phase, so the data must not change here.
  - On i_tx_done:
    - Last index (12, or 9 when SHOW_CSEC = 0): pulse o_done, clear o_busy, go to IDLE.
    - Otherwise: index + 1, go to SEND.
  - Earliest next start is 1 cycle after done.
  - Counter reaching TIMEOUT - 1 without done: pulse o_err, clear o_busy, go to IDLE.
- Byte order (SHOW_CSEC = 1): H1 H0 ':'(3A) M1 M0 ':' S1 S0 '.'(2E) C1 C0 CR(0D) LF(0A).
  - SHOW_CSEC = 0 omits '.', C1 and C0.
- Digit conversion:
  - Value 0-99: tens = v/10, ones = v%10, via combinational compare/subtract.
  - Value 24-31 for hours prints as-is (e.g. 31 -> "31").
- Message boundaries:
  - i_send while o_busy = 1 is ignored; the request is not queued.
  - i_send in the same cycle as o_done is ignored; the next request is accepted from the following cycle.
  - Time inputs changing during a message have no effect (snapshot only).
- Reset mid-message: returns to IDLE immediately, with no further o_tx_start. The transmitter may still finish its current byte, and that byte's done pulse is ignored in IDLE.
- A stray i_tx_done in IDLE, LOAD or SEND is ignored.
- o_done and o_err are mutually exclusive.

Decomposition:
- Shared package/header: state encodings (IDLE = 0, LOAD = 1, SEND = 2, WAIT = 3); ASCII constants ASCII_0 = 8'h30, COLON = 8'h3A, DOT = 8'h2E, CR = 8'h0D, LF = 8'h0A; message lengths 13 and 10.
- One sub-module: bin2ascii_2d. Input 7-bit value, clamped at 99; outputs two 8-bit ASCII digits; combinational. Instantiated four times.

Test Plan:
- 12:34:56.78, pulse i_send, transmitter model with done 20 cycles after each start -> o_tx_data sequence 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A; 13 start pulses; one o_done after the 13th done.
- SHOW_CSEC = 0, time 00:00:09 -> bytes 30 30 3A 30 30 3A 30 39 0D 0A; o_done after the 10th done.
- Second i_send mid-message, plus i_sec changed from 56 to 57 during the message -> still a single 13-byte message showing 56; no extra start pulses.
- i_csec = 120 -> C1/C0 = 39 39. i_hour = 31 -> 33 31.
- Transmitter model never returns done, with TIMEOUT = 100 -> o_err pulse exactly 100 cycles after the first start; o_busy = 0; back in IDLE.
- rst asserted during WAIT of byte 5 -> next cycle all outputs at reset values; the late done is ignored; a new i_send produces a full 13-byte message.

Source files
------------

// File: rtl/uart_time_sender_pkg.sv
// Shared constants and types for the time-string UART feeder.
// FSM encodings, ASCII characters, message lengths, digit-pair bundle.
package uart_time_sender_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] DOT     = 8'h2E;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;

  localparam int unsigned MSG_LEN_CSEC   = 13;
  localparam int unsigned MSG_LEN_NOCSEC = 10;

  typedef struct packed {
    logic [7:0] tens;
    logic [7:0] ones;
  } digits_t;

endpackage

// File: rtl/uart_time_sender_bin2ascii_2d.sv
// Combinational 0-99 to two ASCII digits; inputs above 99 clamp to 99.
// Ports: val_i (7b value), tens_o / ones_o (ASCII digits).
module bin2ascii_2d
  import uart_time_sender_pkg::*;
(
  input  logic [6:0] val_i,
  output logic [7:0] tens_o,
  output logic [7:0] ones_o
);

  logic [6:0] r;
  logic [3:0] t;

  // Restoring divide by 10: subtract 80/40/20/10 in turn.
  always_comb begin
    r = (val_i > 7'd99) ? 7'd99 : val_i;
    t = 4'd0;
    if (r >= 7'd80) begin
      r = r - 7'd80;
      t = t + 4'd8;
    end
    if (r >= 7'd40) begin
      r = r - 7'd40;
      t = t + 4'd4;
    end
    if (r >= 7'd20) begin
      r = r - 7'd20;
      t = t + 4'd2;
    end
    if (r >= 7'd10) begin
      r = r - 7'd10;
      t = t + 4'd1;
    end
    tens_o = ASCII_0 + {4'd0, t};
    ones_o = ASCII_0 + {1'b0, r};
  end

endmodule

// File: rtl/uart_time_sender.sv
// Snapshots the time on i_send and streams "HH:MM:SS[.CC]\r\n" to a UART TX.
// Ports: clk/rst, i_send, i_hour/min/sec/csec, i_tx_busy/done -> o_tx_*, o_busy/done/err.
module uart_time_sender
  import uart_time_sender_pkg::*;
#(
  parameter int SHOW_CSEC = 1,
  parameter int TIMEOUT   = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_send,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_csec,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX =
    (SHOW_CSEC != 0) ? 4'(MSG_LEN_CSEC - 1) : 4'(MSG_LEN_NOCSEC - 1);

  logic [1:0]          state_q, state_d;
  logic [4:0]          hour_q, hour_d;
  logic [5:0]          min_q, min_d;
  logic [5:0]          sec_q, sec_d;
  logic [6:0]          csec_q, csec_d;
  digits_t [3:0]       dig_q, dig_d;
  logic [3:0]          idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                start_q, start_d;
  logic [7:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  digits_t [3:0]       conv;
  logic [3:0]          pos;
  logic [7:0]          cur_byte;

  bin2ascii_2d u_hour (
    .val_i  ({2'b00, hour_q}),
    .tens_o (conv[0].tens),
    .ones_o (conv[0].ones)
  );

  bin2ascii_2d u_min (
    .val_i  ({1'b0, min_q}),
    .tens_o (conv[1].tens),
    .ones_o (conv[1].ones)
  );

  bin2ascii_2d u_sec (
    .val_i  ({1'b0, sec_q}),
    .tens_o (conv[2].tens),
    .ones_o (conv[2].ones)
  );

  bin2ascii_2d u_csec (
    .val_i  (csec_q),
    .tens_o (conv[3].tens),
    .ones_o (conv[3].ones)
  );

  // Without centiseconds the tail "CR LF" sits at index 8/9;
  // map it onto the full 13-byte layout.
  always_comb begin
    pos = idx_q;
    if (SHOW_CSEC == 0 && idx_q >= 4'd8) begin
      pos = idx_q + 4'd3;
    end
    case (pos)
      4'd0:    cur_byte = dig_q[0].tens;
      4'd1:    cur_byte = dig_q[0].ones;
      4'd2:    cur_byte = COLON;
      4'd3:    cur_byte = dig_q[1].tens;
      4'd4:    cur_byte = dig_q[1].ones;
      4'd5:    cur_byte = COLON;
      4'd6:    cur_byte = dig_q[2].tens;
      4'd7:    cur_byte = dig_q[2].ones;
      4'd8:    cur_byte = DOT;
      4'd9:    cur_byte = dig_q[3].tens;
      4'd10:   cur_byte = dig_q[3].ones;
      4'd11:   cur_byte = CR;
      default: cur_byte = LF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    csec_d  = csec_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A request coinciding with the done pulse is dropped.
        if (i_send && !done_q) begin
          hour_d  = i_hour;
          min_d   = i_min;
          sec_d   = i_sec;
          csec_d  = i_csec;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dig_d   = conv;
        idx_d   = 4'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          data_d  = cur_byte;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SEND;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      csec_q  <= '0;
      dig_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      csec_q  <= csec_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_time_sender.sv
// Self-checking bench for uart_time_sender (13-byte and 10-byte variants).
// Behavioural TX models capture bytes; a string-level model predicts them.
module tb_uart_time_sender;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int h;
    int m;
    int s;
    int c;
    logic [7:0] eh1;
    logic [7:0] eh0;
    logic [7:0] ec1;
    logic [7:0] ec0;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_send = 1'b0;
  logic b_send = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic [6:0] csec = '0;

  logic a_txb = 1'b0, a_txd = 1'b0;
  logic a_start, a_busy, a_done, a_err;
  logic [7:0] a_data;
  logic b_txb = 1'b0, b_txd = 1'b0;
  logic b_start, b_busy, b_done, b_err;
  logic [7:0] b_data;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  int a_delay = 20;
  bit a_hang = 1'b0;
  bit a_kill = 1'b0;
  bit a_mbusy = 1'b0;
  int a_cnt = 0;
  logic [7:0] a_cur = '0;
  logic [7:0] a_q[$];
  int a_ndone = 0, a_nerr = 0, a_unst = 0, a_both = 0;
  int a_tstart = 0, a_terr = 0;

  bit b_mbusy = 1'b0;
  int b_cnt = 0;
  logic [7:0] b_cur = '0;
  logic [7:0] b_q[$];
  int b_ndone = 0, b_nerr = 0, b_unst = 0;

  always #5 clk = ~clk;

  uart_time_sender #(.SHOW_CSEC(1), .TIMEOUT(100)) dut_a (
    .clk(clk), .rst(rst), .i_send(a_send),
    .i_hour(hour), .i_min(min), .i_sec(sec), .i_csec(csec),
    .i_tx_busy(a_txb), .i_tx_done(a_txd),
    .o_tx_start(a_start), .o_tx_data(a_data),
    .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
  );

  uart_time_sender #(.SHOW_CSEC(0), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .i_send(b_send),
    .i_hour(hour), .i_min(min), .i_sec(sec), .i_csec(csec),
    .i_tx_busy(b_txb), .i_tx_done(b_txd),
    .o_tx_start(b_start), .o_tx_data(b_data),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
  );

  // TX model A: done a_delay cycles after start, or never when hung.
  always @(posedge clk) begin
    #2;
    cyc++;
    a_txd = 1'b0;
    if (a_kill) begin
      a_mbusy = 1'b0;
      a_kill = 1'b0;
    end
    if (a_mbusy) begin
      if (a_data !== a_cur) a_unst++;
      a_cnt++;
      if (!a_hang && a_cnt == a_delay) begin
        a_txd = 1'b1;
        a_mbusy = 1'b0;
      end
    end
    if (a_start) begin
      if (a_q.size() == 0) a_tstart = cyc;
      a_q.push_back(a_data);
      a_cur = a_data;
      a_mbusy = 1'b1;
      a_cnt = 0;
    end
    if (a_done) a_ndone++;
    if (a_err) begin
      a_nerr++;
      a_terr = cyc;
    end
    if (a_done && a_err) a_both++;
    a_txb = a_mbusy;
  end

  // TX model B: short fixed latency.
  always @(posedge clk) begin
    #2;
    b_txd = 1'b0;
    if (b_mbusy) begin
      if (b_data !== b_cur) b_unst++;
      b_cnt++;
      if (b_cnt == 3) begin
        b_txd = 1'b1;
        b_mbusy = 1'b0;
      end
    end
    if (b_start) begin
      b_q.push_back(b_data);
      b_cur = b_data;
      b_mbusy = 1'b1;
      b_cnt = 0;
    end
    if (b_done) b_ndone++;
    if (b_err) b_nerr++;
    b_txb = b_mbusy;
  end

  function automatic bq_t ref_msg(int h, int m, int s, int c, bit show);
    bq_t q;
    int cc;
    cc = (c > 99) ? 99 : c;
    q.push_back(8'(48 + h / 10));
    q.push_back(8'(48 + h % 10));
    q.push_back(8'h3A);
    q.push_back(8'(48 + m / 10));
    q.push_back(8'(48 + m % 10));
    q.push_back(8'h3A);
    q.push_back(8'(48 + s / 10));
    q.push_back(8'(48 + s % 10));
    if (show) begin
      q.push_back(8'h2E);
      q.push_back(8'(48 + cc / 10));
      q.push_back(8'(48 + cc % 10));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_msg(string name, bq_t got, bq_t exp);
    int first;
    first = -1;
    for (int i = 0; i < exp.size(); i++) begin
      if (first < 0 && (i >= got.size() || got[i] !== exp[i])) first = i;
    end
    if (first < 0 && got.size() != exp.size()) first = exp.size();
    nvec++;
    if (first >= 0) begin
      nfail++;
      $display("FAIL %s: got len %0d byte[%0d]=%0h expected len %0d byte=%0h",
               name, got.size(), first,
               (first < got.size()) ? got[first] : 8'h00,
               exp.size(), (first < exp.size()) ? exp[first] : 8'h00);
    end
  endtask

  task automatic set_time(int h, int m, int s, int c);
    hour = 5'(h);
    min = 6'(m);
    sec = 6'(s);
    csec = 7'(c);
  endtask

  task automatic clear_a();
    a_q.delete();
    a_ndone = 0;
    a_nerr = 0;
    a_unst = 0;
  endtask

  task automatic pulse_a();
    check("busy_before_send", a_busy, 0);
    a_send = 1'b1;
    step();
    a_send = 1'b0;
    check("busy_rise", a_busy, 1);
  endtask

  task automatic wait_a(int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (a_done || a_err) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      nfail++;
      $display("FAIL wait_a: no done/err within %0d cycles", max);
    end
  endtask

  task automatic wait_a_bytes(int n, int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (a_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      nfail++;
      $display("FAIL wait_bytes: got %0d expected %0d", a_q.size(), n);
    end
  endtask

  task automatic run_a(int h, int m, int s, int c);
    set_time(h, m, s, c);
    clear_a();
    pulse_a();
    wait_a(2000);
    step();
  endtask

  task automatic check_a_msg(string name, int h, int m, int s, int c);
    check_msg(name, a_q, ref_msg(h, m, s, c, 1'b1));
    check({name, "_ndone"}, a_ndone, 1);
    check({name, "_nerr"}, a_nerr, 0);
    check({name, "_unstable"}, a_unst, 0);
  endtask

  task automatic run_b(int h, int m, int s, int c);
    bit ok;
    set_time(h, m, s, c);
    b_q.delete();
    b_ndone = 0;
    b_nerr = 0;
    b_unst = 0;
    b_send = 1'b1;
    step();
    b_send = 1'b0;
    check("b_busy_rise", b_busy, 1);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (b_done || b_err) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      nfail++;
      $display("FAIL wait_b: no done/err within 1000 cycles");
    end
    step();
    check_msg("b_msg", b_q, ref_msg(h, m, s, c, 1'b0));
    check("b_ndone", b_ndone, 1);
    check("b_nerr", b_nerr, 0);
    check("b_unstable", b_unst, 0);
  endtask

  initial begin
    vec_t tbl[5];
    bq_t b_exp;
    int h, m, s, c;

    tbl[0] = '{12, 34, 56, 78, 8'h31, 8'h32, 8'h37, 8'h38};
    tbl[1] = '{31, 0, 0, 120, 8'h33, 8'h31, 8'h39, 8'h39};
    tbl[2] = '{0, 0, 0, 0, 8'h30, 8'h30, 8'h30, 8'h30};
    tbl[3] = '{23, 59, 59, 99, 8'h32, 8'h33, 8'h39, 8'h39};
    tbl[4] = '{9, 63, 63, 127, 8'h30, 8'h39, 8'h39, 8'h39};

    repeat (3) step();
    check("rst_start", a_start, 0);
    check("rst_data", a_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_a(tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].c);
      check_a_msg("tbl_msg", tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].c);
      check("tbl_hour", {a_q[0], a_q[1]}, {tbl[i].eh1, tbl[i].eh0});
      check("tbl_csec", {a_q[9], a_q[10]}, {tbl[i].ec1, tbl[i].ec0});
      check("tbl_starts", a_q.size(), 13);
    end

    // Second request mid-message and a changing second input.
    set_time(12, 34, 56, 78);
    clear_a();
    pulse_a();
    wait_a_bytes(3, 200);
    a_send = 1'b1;
    sec = 6'd57;
    step();
    a_send = 1'b0;
    wait_a(2000);
    step();
    check_a_msg("midsend", 12, 34, 56, 78);
    repeat (30) step();
    check("midsend_starts", a_q.size(), 13);

    // Request in the same cycle as o_done is dropped.
    set_time(1, 2, 3, 4);
    clear_a();
    pulse_a();
    wait_a(2000);
    check("collide_done_seen", a_done, 1);
    a_send = 1'b1;
    step();
    a_send = 1'b0;
    repeat (5) step();
    check("collide_busy", a_busy, 0);
    check("collide_starts", a_q.size(), 13);
    run_a(5, 6, 7, 8);
    check_a_msg("after_collide", 5, 6, 7, 8);

    // Timeout: the transmitter never finishes.
    a_hang = 1'b1;
    run_a(10, 20, 30, 40);
    check("to_nerr", a_nerr, 1);
    check("to_ndone", a_ndone, 0);
    check("to_latency", a_terr - a_tstart, 100);
    check("to_busy", a_busy, 0);
    check("to_starts", a_q.size(), 1);
    a_hang = 1'b0;
    a_kill = 1'b1;
    repeat (3) step();

    // Reset during the wait for byte 5.
    set_time(12, 34, 56, 78);
    clear_a();
    pulse_a();
    wait_a_bytes(5, 300);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("mrst_start", a_start, 0);
    check("mrst_data", a_data, 0);
    check("mrst_busy", a_busy, 0);
    check("mrst_done", a_done, 0);
    check("mrst_err", a_err, 0);
    rst = 1'b0;
    repeat (30) step();
    check("mrst_starts", a_q.size(), 5);
    check("mrst_ndone", a_ndone, 0);
    check("mrst_busy_late", a_busy, 0);
    run_a(12, 34, 56, 78);
    check_a_msg("after_rst", 12, 34, 56, 78);

    for (int i = 0; i < 8; i++) begin
      h = int'($urandom_range(0, 31));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      c = int'($urandom_range(0, 127));
      run_a(h, m, s, c);
      check_a_msg("rand_msg", h, m, s, c);
    end

    run_b(0, 0, 9, 55);
    b_exp = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30,
              8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A};
    check_msg("b_literal", b_q, b_exp);
    for (int i = 0; i < 3; i++) begin
      h = int'($urandom_range(0, 31));
      m = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 63));
      c = int'($urandom_range(0, 127));
      run_b(h, m, s, c);
    end

    check("done_err_exclusive", a_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
